// File: rtl/mux_unstriping_pkg.sv
// Shared PCIe PHY lane constants and lane-select type, common to the
// striping demux and the unstriping mux.
package mux_unstriping_pkg;

   localparam int LANE_WIDTH = 32;
   localparam int NUM_LANES  = 2;

   typedef enum logic {
      LANE_0 = 1'b0,
      LANE_1 = 1'b1
   } lane_sel_t;

   // Round-robin successor; with two lanes this is a plain toggle.
   function automatic lane_sel_t next_lane(input lane_sel_t cur);
      return (cur == LANE_0) ? LANE_1 : LANE_0;
   endfunction

endpackage

// File: rtl/mux_unstriping_fifo.sv
// Per-lane elastic FIFO: synchronous write, registered pointers, head word
// visible combinationally on dout. A push into a full FIFO is accepted only
// when a pop on the same edge frees a slot.
module lane_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk_2f,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_FULL);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge clk_2f or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; empty/full come from the
   // pointers and count, so stale entries are never observed.
   always_ff @(posedge clk_2f) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/mux_unstriping.sv
// Receive-side byte unstriping: merges two skewed 32-bit lanes back into one
// stream in strict lane_0, lane_1, lane_0 ... order through per-lane FIFOs.
module mux_unstriping
   import mux_unstriping_pkg::*;
#(
   parameter int WIDTH = LANE_WIDTH,
   parameter int DEPTH = 4
) (
   input  logic             clk_2f,
   input  logic             reset,
   input  logic [WIDTH-1:0] lane_0,
   input  logic             valid_in0,
   input  logic [WIDTH-1:0] lane_1,
   input  logic             valid_in1,
   output logic [WIDTH-1:0] data_out,
   output logic             valid_out,
   output logic             overflow
);

   lane_sel_t        sel;
   logic [WIDTH-1:0] dout0, dout1;
   logic             empty0, empty1;
   logic             full0, full1;
   logic             pop0, pop1;
   logic             pop_any;
   logic             drop0, drop1;
   logic [WIDTH-1:0] head;

   lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
      .clk_2f (clk_2f),
      .reset  (reset),
      .push   (valid_in0),
      .din    (lane_0),
      .pop    (pop0),
      .dout   (dout0),
      .empty  (empty0),
      .full   (full0)
   );

   lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
      .clk_2f (clk_2f),
      .reset  (reset),
      .push   (valid_in1),
      .din    (lane_1),
      .pop    (pop1),
      .dout   (dout1),
      .empty  (empty1),
      .full   (full1)
   );

   // Only the selected lane may drain; the other waits even if it has data,
   // which is what keeps the merged order intact.
   assign pop0    = (sel == LANE_0) && !empty0;
   assign pop1    = (sel == LANE_1) && !empty1;
   assign pop_any = pop0 || pop1;
   assign head    = (sel == LANE_1) ? dout1 : dout0;

   // A full FIFO is never empty, so a same-edge pop always frees the slot.
   assign drop0 = valid_in0 && full0 && !pop0;
   assign drop1 = valid_in1 && full1 && !pop1;

   always_ff @(posedge clk_2f or negedge reset) begin
      if (!reset) begin
         data_out  <= '0;
         valid_out <= 1'b0;
         overflow  <= 1'b0;
         sel       <= LANE_0;
      end else begin
         valid_out <= pop_any;
         if (pop_any) begin
            data_out <= head;
            sel      <= next_lane(sel);
         end
         if (drop0 || drop1) overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mux_unstriping.sv
// Directed self-checking bench for mux_unstriping: reset, merge order, skew,
// starvation, overflow and full-FIFO push with simultaneous pop.
module tb_mux_unstriping;
   import mux_unstriping_pkg::*;

   localparam int W = 32;

   logic          clk_2f = 1'b0;
   logic          reset;
   logic [W-1:0]  lane_0, lane_1;
   logic          valid_in0, valid_in1;
   logic [W-1:0]  data_out;
   logic          valid_out;
   logic          overflow;

   int n_cmp = 0;
   int n_err = 0;

   mux_unstriping #(.WIDTH(W), .DEPTH(4)) dut (
      .clk_2f    (clk_2f),
      .reset     (reset),
      .lane_0    (lane_0),
      .valid_in0 (valid_in0),
      .lane_1    (lane_1),
      .valid_in1 (valid_in1),
      .data_out  (data_out),
      .valid_out (valid_out),
      .overflow  (overflow)
   );

   always #5 clk_2f = ~clk_2f;

   // Drive one edge's worth of input, then sample 1 time unit after the edge.
   task automatic cycle(input logic v0, input logic [W-1:0] d0,
                        input logic v1, input logic [W-1:0] d1);
      valid_in0 = v0; lane_0 = d0;
      valid_in1 = v1; lane_1 = d1;
      @(posedge clk_2f);
      #1;
      valid_in0 = 1'b0; valid_in1 = 1'b0;
   endtask

   task automatic do_reset();
      valid_in0 = 1'b0; valid_in1 = 1'b0;
      lane_0 = '0; lane_1 = '0;
      reset = 1'b0;
      repeat (2) @(posedge clk_2f);
      #1;
      reset = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if (data_out !== 32'h0 || valid_out !== 1'b0 || overflow !== 1'b0) begin
         n_err++;
         $display("FAIL reset_state: got d=%h v=%b ovf=%b want d=0 v=0 ovf=0",
                  data_out, valid_out, overflow);
      end
   endtask

   task automatic test_merge();
      do_reset();
      for (int c = 0; c <= 7; c++) begin
         cycle((c % 2 == 0) && c <= 4, W'(32'h10 + c),
               (c % 2 == 1) && c <= 5, W'(32'h10 + c));
         n_cmp++;
         if (c >= 1 && c <= 6) begin
            if (valid_out !== 1'b1 || data_out !== W'(32'h10 + c - 1)) begin
               n_err++;
               $display("FAIL merge[%0d]: got v=%b d=%h want v=1 d=%h",
                        c, valid_out, data_out, 32'h10 + c - 1);
            end
         end else if (valid_out !== 1'b0) begin
            n_err++;
            $display("FAIL merge_idle[%0d]: got v=%b want v=0", c, valid_out);
         end
      end
   endtask

   task automatic test_skew();
      logic [W-1:0] exp_d [10];
      exp_d = '{0, 0, 0, 0, 32'h20, 32'h21, 32'h22, 32'h23, 32'h24, 32'h25};
      do_reset();
      for (int c = 0; c <= 9; c++) begin
         cycle(c >= 3 && c <= 5, W'(32'h20 + 2 * (c - 3)),
               c <= 2,           W'(32'h21 + 2 * c));
         n_cmp++;
         if (valid_out !== (c >= 4) || (c >= 4 && data_out !== exp_d[c])) begin
            n_err++;
            $display("FAIL skew[%0d]: got v=%b d=%h want v=%b d=%h",
                     c, valid_out, data_out, c >= 4, exp_d[c]);
         end
      end
      n_cmp++;
      if (overflow !== 1'b0) begin
         n_err++;
         $display("FAIL skew_overflow: got %b want 0", overflow);
      end
   endtask

   task automatic test_starvation();
      do_reset();
      cycle(1'b1, 32'hA0, 1'b0, '0);
      n_cmp++;
      if (valid_out !== 1'b0) begin
         n_err++;
         $display("FAIL starve_latency: got v=%b want 0", valid_out);
      end
      cycle(1'b0, '0, 1'b0, '0);
      n_cmp++;
      if (valid_out !== 1'b1 || data_out !== 32'hA0 || dut.sel !== LANE_1) begin
         n_err++;
         $display("FAIL starve_a0: got v=%b d=%h sel=%b want v=1 d=a0 sel=1",
                  valid_out, data_out, dut.sel);
      end
      for (int c = 2; c <= 6; c++) begin
         cycle(1'b0, '0, c == 6, 32'hB0);
         n_cmp++;
         if (valid_out !== 1'b0 || data_out !== 32'hA0 || dut.sel !== LANE_1) begin
            n_err++;
            $display("FAIL starve_idle[%0d]: got v=%b d=%h sel=%b want v=0 d=a0 sel=1",
                     c, valid_out, data_out, dut.sel);
         end
      end
      cycle(1'b0, '0, 1'b0, '0);
      n_cmp++;
      if (valid_out !== 1'b1 || data_out !== 32'hB0 || dut.sel !== LANE_0) begin
         n_err++;
         $display("FAIL starve_b0: got v=%b d=%h sel=%b want v=1 d=b0 sel=0",
                  valid_out, data_out, dut.sel);
      end
   endtask

   task automatic test_overflow();
      logic [W-1:0] exp_d [16];
      logic         exp_v [16];
      exp_d = '{0, 0, 0, 0, 0, 0, 32'h40, 32'h31, 32'h41, 32'h32,
                32'h42, 32'h33, 32'h43, 32'h34, 32'h44, 0};
      exp_v = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
      do_reset();
      for (int c = 0; c <= 15; c++) begin
         cycle((c >= 5 && c <= 8) || c == 13,
               (c == 13) ? W'(32'h44) : W'(32'h40 + c - 5),
               c <= 4, W'(32'h31 + c));
         n_cmp++;
         if (overflow !== (c >= 4)) begin
            n_err++;
            $display("FAIL ovf_flag[%0d]: got %b want %b", c, overflow, c >= 4);
         end
         n_cmp++;
         if (valid_out !== exp_v[c] || (exp_v[c] && data_out !== exp_d[c])) begin
            n_err++;
            $display("FAIL ovf_data[%0d]: got v=%b d=%h want v=%b d=%h",
                     c, valid_out, data_out, exp_v[c], exp_d[c]);
         end
      end
      do_reset();
      n_cmp++;
      if (overflow !== 1'b0) begin
         n_err++;
         $display("FAIL ovf_clear: got %b want 0", overflow);
      end
   endtask

   task automatic test_full_pop();
      logic [W-1:0] exp_d [17];
      logic         exp_v [17];
      logic         v0, v1;
      logic [W-1:0] d0, d1;
      exp_d = '{0, 32'h50, 0, 0, 0, 0, 32'h60, 32'h51, 32'h61, 32'h52,
                32'h62, 32'h53, 32'h63, 32'h54, 32'h64, 32'hFF, 0};
      exp_v = '{0, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
      do_reset();
      for (int c = 0; c <= 16; c++) begin
         v0 = (c <= 4) || (c == 7);
         d0 = (c == 7) ? W'(32'hFF) : W'(32'h50 + c);
         v1 = (c == 5) || (c >= 7 && c <= 10);
         d1 = (c == 5) ? W'(32'h60) : W'(32'h61 + c - 7);
         cycle(v0, d0, v1, d1);
         n_cmp++;
         if (valid_out !== exp_v[c] || (exp_v[c] && data_out !== exp_d[c])) begin
            n_err++;
            $display("FAIL fullpop[%0d]: got v=%b d=%h want v=%b d=%h",
                     c, valid_out, data_out, exp_v[c], exp_d[c]);
         end
      end
      n_cmp++;
      if (overflow !== 1'b0) begin
         n_err++;
         $display("FAIL fullpop_overflow: got %b want 0", overflow);
      end
   endtask

   task automatic test_reset_midstream();
      do_reset();
      for (int c = 0; c <= 4; c++)
         cycle(c <= 3, W'(32'hC0 + c), c <= 3, W'(32'hD0 + c));
      n_cmp++;
      if (valid_out !== 1'b1 || data_out !== 32'hD1) begin
         n_err++;
         $display("FAIL mid_pre: got v=%b d=%h want v=1 d=d1", valid_out, data_out);
      end
      #1;
      reset = 1'b0;
      #1;
      n_cmp++;
      if (data_out !== 32'h0 || valid_out !== 1'b0 || overflow !== 1'b0) begin
         n_err++;
         $display("FAIL mid_async: got d=%h v=%b ovf=%b want 0/0/0",
                  data_out, valid_out, overflow);
      end
      @(posedge clk_2f);
      #1;
      reset = 1'b1;
      cycle(1'b1, 32'hAAAA0001, 1'b1, 32'hBBBB0001);
      cycle(1'b0, '0, 1'b0, '0);
      n_cmp++;
      if (valid_out !== 1'b1 || data_out !== 32'hAAAA0001) begin
         n_err++;
         $display("FAIL mid_first: got v=%b d=%h want v=1 d=aaaa0001",
                  valid_out, data_out);
      end
      cycle(1'b0, '0, 1'b0, '0);
      n_cmp++;
      if (valid_out !== 1'b1 || data_out !== 32'hBBBB0001) begin
         n_err++;
         $display("FAIL mid_second: got v=%b d=%h want v=1 d=bbbb0001",
                  valid_out, data_out);
      end
      cycle(1'b0, '0, 1'b0, '0);
      n_cmp++;
      if (valid_out !== 1'b0) begin
         n_err++;
         $display("FAIL mid_discard: got v=%b d=%h want v=0", valid_out, data_out);
      end
   endtask

   initial begin
      reset = 1'b0;
      valid_in0 = 1'b0; valid_in1 = 1'b0;
      lane_0 = '0; lane_1 = '0;
      test_reset();
      test_merge();
      test_skew();
      test_starvation();
      test_overflow();
      test_full_pop();
      test_reset_midstream();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
